bits2bytes_stream: RTL and testbench

- Streaming bit-vector to byte serializer; the inverse direction of the byte-packing conversion stage.
- Accepts one N_BYTES*8-bit word over a valid/ready handshake and emits it as N_BYTES bytes, least-significant byte first, over a second valid/ready handshake.
- Feeds byte-oriented consumers (hash/XOF absorb, output buffers) from the bit-domain compression/encode datapath.

---
 rtl/bits2bytes_stream.sv | 110 +++++++++++
 tb/tb_bits2bytes_stream.sv | 237 +++++++++++++++++++++++
 2 files changed

// File: rtl/bits2bytes_stream.sv
// bits2bytes_stream: accepts one N_BYTES*8-bit word over a valid/ready
// handshake and emits it least-significant byte first over a byte stream.
// Optional build macro BITS2BYTES_STREAM_BACKTOBACK_EN lets a new word load
// on the same edge as the last byte of the current word, which removes the
// idle bubble between words. This adds a combinational byte_ready_i ->
// bits_ready_o path.
module bits2bytes_stream #(
  parameter int N_BYTES = 4
) (
  input  logic                 clk_i,
  input  logic                 rst_ni,
  input  logic [N_BYTES*8-1:0] bits_i,
  input  logic                 bits_valid_i,
  output logic                 bits_ready_o,
  output logic [7:0]           byte_o,
  output logic                 byte_valid_o,
  input  logic                 byte_ready_i,
  output logic                 byte_last_o,
  output logic                 busy_o
);

  localparam int WordW = N_BYTES * 8;
  localparam int IdxW  = (N_BYTES > 1) ? $clog2(N_BYTES) : 1;
  localparam logic [IdxW-1:0] LastIdx = IdxW'(N_BYTES - 1);

  if (N_BYTES < 1) begin : gen_bad_param
    $error("bits2bytes_stream: N_BYTES must be >= 1");
  end

  typedef enum logic [0:0] {StIdle, StSend} state_e;

  state_e           state_q, state_d;
  logic [WordW-1:0] sreg_q, sreg_d;
  logic [IdxW-1:0]  idx_q, idx_d;
  logic             in_xfer, out_xfer, at_last;

  assign at_last  = (idx_q == LastIdx);
  assign in_xfer  = bits_valid_i && bits_ready_o;
  assign out_xfer = byte_valid_o && byte_ready_i;

  // State, shift register and byte index; async reset discards any held word.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= StIdle;
      sreg_q  <= '0;
      idx_q   <= '0;
    end else begin
      state_q <= state_d;
      sreg_q  <= sreg_d;
      idx_q   <= idx_d;
    end
  end

  // Next-state: load on input transfer, shift out one byte per output transfer.
  always_comb begin
    state_d = state_q;
    sreg_d  = sreg_q;
    idx_d   = idx_q;
    unique case (state_q)
      StIdle: begin
        if (in_xfer) begin
          sreg_d  = bits_i;
          idx_d   = '0;
          state_d = StSend;
        end
      end
      StSend: begin
        if (out_xfer) begin
          if (!at_last) begin
            sreg_d = sreg_q >> 8;
            idx_d  = idx_q + 1'b1;
          end else if (in_xfer) begin
            // Only reachable when back-to-back loading is enabled.
            sreg_d  = bits_i;
            idx_d   = '0;
            state_d = StSend;
          end else begin
            state_d = StIdle;
          end
        end
      end
      default: state_d = StIdle;
    endcase
  end

  // Outputs decoded from registered state; byte_o forced to zero outside SEND.
  always_comb begin
    bits_ready_o = 1'b0;
    byte_valid_o = 1'b0;
    busy_o       = 1'b0;
    byte_o       = 8'h00;
    byte_last_o  = 1'b0;
    unique case (state_q)
      StIdle: bits_ready_o = 1'b1;
      StSend: begin
        byte_valid_o = 1'b1;
        busy_o       = 1'b1;
        byte_o       = sreg_q[7:0];
        byte_last_o  = at_last;
`ifdef BITS2BYTES_STREAM_BACKTOBACK_EN
        bits_ready_o = at_last && byte_ready_i;
`else
        bits_ready_o = 1'b0;
`endif
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_bits2bytes_stream.sv
// Directed self-checking bench for bits2bytes_stream (N_BYTES=4 and N_BYTES=1).
module tb_bits2bytes_stream;

  logic        clk = 1'b0;
  logic        rst_n = 1'b1;

  // N_BYTES=4 instance signals
  logic [31:0] bits0 = '0;
  logic        bv0 = 1'b0, br0, bvo0, rdy0 = 1'b0, last0, busy0;
  logic [7:0]  byte0;

  // N_BYTES=1 instance signals
  logic [7:0]  bits1 = '0;
  logic        bv1 = 1'b0, br1, bvo1, rdy1 = 1'b0, last1, busy1;
  logic [7:0]  byte1;

  int total = 0;
  int bad   = 0;

`ifdef BITS2BYTES_STREAM_BACKTOBACK_EN
  localparam int Gap = 4;
`else
  localparam int Gap = 5;
`endif

  always #5 clk = ~clk;

  bits2bytes_stream #(.N_BYTES(4)) u0 (
    .clk_i(clk), .rst_ni(rst_n), .bits_i(bits0), .bits_valid_i(bv0), .bits_ready_o(br0),
    .byte_o(byte0), .byte_valid_o(bvo0), .byte_ready_i(rdy0), .byte_last_o(last0),
    .busy_o(busy0)
  );

  bits2bytes_stream #(.N_BYTES(1)) u1 (
    .clk_i(clk), .rst_ni(rst_n), .bits_i(bits1), .bits_valid_i(bv1), .bits_ready_o(br1),
    .byte_o(byte1), .byte_valid_o(bvo1), .byte_ready_i(rdy1), .byte_last_o(last1),
    .busy_o(busy1)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Check u0 presents byte b with the given last flag at the next negedge.
  task automatic chk_byte0(input string tag, input logic [7:0] b, input logic l);
    @(negedge clk);
    chk({tag, "_valid"}, {31'd0, bvo0}, 32'd1);
    chk({tag, "_byte"}, {24'd0, byte0}, {24'd0, b});
    chk({tag, "_last"}, {31'd0, last0}, {31'd0, l});
  endtask

  task automatic chk_idle0(input string tag);
    @(negedge clk);
    chk({tag, "_valid"}, {31'd0, bvo0}, 32'd0);
    chk({tag, "_busy"}, {31'd0, busy0}, 32'd0);
    chk({tag, "_ready"}, {31'd0, br0}, 32'd1);
  endtask

  logic [7:0] exp3 [8];
  int         k;
  bit         acc;

  initial begin
    exp3[0] = 8'h00; exp3[1] = 8'h01; exp3[2] = 8'h02; exp3[3] = 8'h03;
    exp3[4] = 8'hFF; exp3[5] = 8'hFF; exp3[6] = 8'hFF; exp3[7] = 8'hFF;

    // Reset state
    #1 rst_n = 1'b0;
    #2;
    chk("rst_valid", {31'd0, bvo0}, 32'd0);
    chk("rst_busy", {31'd0, busy0}, 32'd0);
    chk("rst_byte", {24'd0, byte0}, 32'd0);
    chk("rst_last", {31'd0, last0}, 32'd0);
    chk("rst1_valid", {31'd0, bvo1}, 32'd0);
    @(posedge clk);
    @(posedge clk);
    #2 rst_n = 1'b1;

    // 1. Ordering
    bits0 = 32'h89ABCDEF; bv0 = 1'b1; rdy0 = 1'b1;
    @(negedge clk);
    chk("t1_ready", {31'd0, br0}, 32'd1);
    tick();
    bv0 = 1'b0;
    chk_byte0("t1_b0", 8'hEF, 1'b0);
    chk("t1_busy", {31'd0, busy0}, 32'd1);
    tick();
    chk_byte0("t1_b1", 8'hCD, 1'b0);
    tick();
    chk_byte0("t1_b2", 8'hAB, 1'b0);
    tick();
    chk_byte0("t1_b3", 8'h89, 1'b1);
    tick();
    chk_idle0("t1_end");
    tick();

    // 2. Backpressure while CD is presented
    bits0 = 32'h89ABCDEF; bv0 = 1'b1;
    tick();
    bv0 = 1'b0;
    chk_byte0("t2_b0", 8'hEF, 1'b0);
    tick();
    rdy0 = 1'b0;
    for (int i = 0; i < 3; i++) begin
      chk_byte0("t2_hold", 8'hCD, 1'b0);
      tick();
    end
    rdy0 = 1'b1;
    chk_byte0("t2_b1", 8'hCD, 1'b0);
    tick();
    chk_byte0("t2_b2", 8'hAB, 1'b0);
    tick();
    chk_byte0("t2_b3", 8'h89, 1'b1);
    tick();
    chk_idle0("t2_end");
    tick();

    // 3. Back-to-back words with bits_valid held high
    bits0 = 32'h03020100; bv0 = 1'b1;
    tick();
    bits0 = 32'hFFFFFFFF;
    k = 0;
    for (int n = 0; n < 10; n++) begin
      @(negedge clk);
      if (bvo0) begin
        if (k < 8) begin
          chk("t3_byte", {24'd0, byte0}, {24'd0, exp3[k]});
          chk("t3_cycle", n, (k < 4) ? k : Gap + k - 4);
        end
        k++;
      end
      acc = br0 && bv0;
      tick();
      if (acc) bv0 = 1'b0;
    end
    chk("t3_count", k, 32'd8);
    chk("t3_bv_dropped", {31'd0, bv0}, 32'd0);

`ifndef BITS2BYTES_STREAM_BACKTOBACK_EN
    // 4. Input stall: word offered during SEND is held off until IDLE
    bits0 = 32'h89ABCDEF; bv0 = 1'b1;
    tick();
    bits0 = 32'h00000000;
    chk_byte0("t4_a0", 8'hEF, 1'b0);
    chk("t4_stall0", {31'd0, br0}, 32'd0);
    tick();
    chk_byte0("t4_a1", 8'hCD, 1'b0);
    tick();
    chk_byte0("t4_a2", 8'hAB, 1'b0);
    tick();
    chk_byte0("t4_a3", 8'h89, 1'b1);
    chk("t4_stall3", {31'd0, br0}, 32'd0);
    tick();
    chk_idle0("t4_bubble");
    tick();
    bv0 = 1'b0;
    for (int i = 0; i < 4; i++) begin
      chk_byte0("t4_zero", 8'h00, (i == 3));
      tick();
    end
    chk_idle0("t4_end");
    tick();
`endif

    // 5. Asynchronous reset mid-word
    bits0 = 32'h89ABCDEF; bv0 = 1'b1;
    tick();
    bv0 = 1'b0;
    chk_byte0("t5_b0", 8'hEF, 1'b0);
    tick();
    chk_byte0("t5_b1", 8'hCD, 1'b0);
    tick();
    #1 rst_n = 1'b0;
    #1;
    chk("t5_rst_valid", {31'd0, bvo0}, 32'd0);
    chk("t5_rst_busy", {31'd0, busy0}, 32'd0);
    chk("t5_rst_byte", {24'd0, byte0}, 32'd0);
    @(posedge clk);
    #2 rst_n = 1'b1;
    bits0 = 32'h11223344; bv0 = 1'b1;
    @(negedge clk);
    chk("t5_ready", {31'd0, br0}, 32'd1);
    tick();
    bv0 = 1'b0;
    chk_byte0("t5_n0", 8'h44, 1'b0);
    tick();
    chk_byte0("t5_n1", 8'h33, 1'b0);
    tick();
    chk_byte0("t5_n2", 8'h22, 1'b0);
    tick();
    chk_byte0("t5_n3", 8'h11, 1'b1);
    tick();
    chk_idle0("t5_end");
    tick();

    // 6. N_BYTES=1: every byte is last; hold under backpressure
    bits1 = 8'hA5; bv1 = 1'b1; rdy1 = 1'b0;
    tick();
    bv1 = 1'b0;
    @(negedge clk);
    chk("t6_a_valid", {31'd0, bvo1}, 32'd1);
    chk("t6_a_byte", {24'd0, byte1}, 32'h000000A5);
    chk("t6_a_last", {31'd0, last1}, 32'd1);
    chk("t6_a_ready", {31'd0, br1}, 32'd0);
    tick();
    rdy1 = 1'b1;
    @(negedge clk);
    chk("t6_a_hold", {24'd0, byte1}, 32'h000000A5);
    tick();
    @(negedge clk);
    chk("t6_a_done", {31'd0, bvo1}, 32'd0);
    bits1 = 8'h5A; bv1 = 1'b1;
    tick();
    bv1 = 1'b0;
    @(negedge clk);
    chk("t6_b_byte", {24'd0, byte1}, 32'h0000005A);
    chk("t6_b_last", {31'd0, last1}, 32'd1);
    chk("t6_b_busy", {31'd0, busy1}, 32'd1);
    tick();
    @(negedge clk);
    chk("t6_b_done", {31'd0, bvo1}, 32'd0);
    chk("t6_b_idle", {31'd0, busy1}, 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
